cmd_responder: RTL and testbench

Quadcopter-side command responder: consumes each command frame assembled by `UART_comm` (`cmd_rdy`/`cmd`/`data`), updates the flight setpoint registers or starts calibration, then returns a one-byte acknowledge over the same link via `send_resp`/`resp`. It sits between `UART_comm` and the flight controller and answers every command the remote initiates. It also contains a link-loss watchdog that forces a safe landing when commands stop arriving.

---
 rtl/cmd_responder.sv | 160 ++++++++++++++++
 tb/tb_cmd_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_responder.sv
// Command responder: decodes frames from UART_comm, updates the flight setpoints and sends a one-byte ack.
// A link-loss watchdog forces all setpoints to zero when commands stop arriving while the motors are on.
module cmd_responder #(
  parameter int WD_WIDTH = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_rdy,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        clr_cmd_rdy,
  output logic [7:0]  resp,
  output logic        send_resp,
  input  logic        resp_sent,
  output logic [15:0] d_ptch,
  output logic [15:0] d_roll,
  output logic [15:0] d_yaw,
  output logic [8:0]  thrst,
  output logic        strt_cal,
  input  logic        cal_done,
  output logic        motors_off,
  output logic        wd_expired
);

  localparam logic [7:0] OP_PTCH  = 8'h02;
  localparam logic [7:0] OP_ROLL  = 8'h03;
  localparam logic [7:0] OP_YAW   = 8'h04;
  localparam logic [7:0] OP_THRST = 8'h05;
  localparam logic [7:0] OP_CAL   = 8'h06;
  localparam logic [7:0] OP_LAND  = 8'h07;
  localparam logic [7:0] OP_MOFF  = 8'h08;
  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_ERR = 8'hEE;
  localparam logic [WD_WIDTH-1:0] WD_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAL_WAIT = 2'd1,
    ACK_SEND = 2'd2,
    ACK_WAIT = 2'd3
  } state_t;

  state_t              state_q;
  logic [15:0]         d_ptch_q, d_roll_q, d_yaw_q;
  logic [8:0]          thrst_q;
  logic [7:0]          resp_q;
  logic                send_resp_q, strt_cal_q, motors_off_q;
  logic                resp_sent_q;
  logic [WD_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
  logic                wd_exp_q, wd_exp_d;
  logic                accept;
  logic                wd_run;

  assign accept      = (state_q == IDLE) && cmd_rdy;
  assign clr_cmd_rdy = accept;
  assign wd_run      = !motors_off_q && (state_q != CAL_WAIT);

  // An accepted command always beats a simultaneous terminal count.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_exp_d = wd_exp_q;
    if (accept) begin
      wd_cnt_d = '0;
      wd_exp_d = 1'b0;
    end else begin
      if (wd_run && (wd_cnt_q != WD_MAX)) begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
      if (wd_cnt_d == WD_MAX) begin
        wd_exp_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      d_ptch_q     <= '0;
      d_roll_q     <= '0;
      d_yaw_q      <= '0;
      thrst_q      <= '0;
      resp_q       <= '0;
      send_resp_q  <= 1'b0;
      strt_cal_q   <= 1'b0;
      motors_off_q <= 1'b1;
      resp_sent_q  <= 1'b0;
      wd_cnt_q     <= '0;
      wd_exp_q     <= 1'b0;
    end else begin
      resp_sent_q <= resp_sent;
      wd_cnt_q    <= wd_cnt_d;
      wd_exp_q    <= wd_exp_d;
      send_resp_q <= 1'b0;
      strt_cal_q  <= 1'b0;

      if (wd_exp_d) begin
        d_ptch_q <= '0;
        d_roll_q <= '0;
        d_yaw_q  <= '0;
        thrst_q  <= '0;
      end

      case (state_q)
        IDLE: begin
          if (cmd_rdy) begin
            resp_q      <= RESP_ACK;
            send_resp_q <= 1'b1;
            state_q     <= ACK_SEND;
            case (cmd)
              OP_PTCH:  d_ptch_q <= data;
              OP_ROLL:  d_roll_q <= data;
              OP_YAW:   d_yaw_q  <= data;
              OP_THRST: thrst_q  <= data[8:0];
              OP_CAL: begin
                strt_cal_q  <= 1'b1;
                send_resp_q <= 1'b0;
                state_q     <= CAL_WAIT;
              end
              OP_LAND: begin
                d_ptch_q <= '0;
                d_roll_q <= '0;
                d_yaw_q  <= '0;
                thrst_q  <= '0;
              end
              OP_MOFF:  motors_off_q <= 1'b1;
              default:  resp_q <= RESP_ERR;
            endcase
          end
        end
        CAL_WAIT: begin
          if (cal_done) begin
            motors_off_q <= 1'b0;
            send_resp_q  <= 1'b1;
            state_q      <= ACK_SEND;
          end
        end
        ACK_SEND: begin
          state_q <= ACK_WAIT;
        end
        ACK_WAIT: begin
          if (resp_sent && !resp_sent_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp       = resp_q;
  assign send_resp  = send_resp_q;
  assign strt_cal   = strt_cal_q;
  assign motors_off = motors_off_q;
  assign wd_expired = wd_exp_q;
  assign d_ptch     = d_ptch_q;
  assign d_roll     = d_roll_q;
  assign d_yaw      = d_yaw_q;
  assign thrst      = thrst_q;

endmodule

// File: tb/tb_cmd_responder.sv
// Directed bench for cmd_responder: each task drives one scenario and checks outputs at the falling edge.
module tb_cmd_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_rdy = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic [15:0] data = 16'h0000;
  logic        resp_sent = 1'b0;
  logic        cal_done = 1'b0;
  logic        clr_cmd_rdy, send_resp, strt_cal, motors_off, wd_expired;
  logic [7:0]  resp;
  logic [15:0] d_ptch, d_roll, d_yaw;
  logic [8:0]  thrst;

  int passed = 0;
  int total  = 0;
  int n_send = 0;
  int n_strt = 0;
  int n_clr  = 0;

  cmd_responder #(.WD_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
    .resp_sent(resp_sent), .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
    .thrst(thrst), .strt_cal(strt_cal), .cal_done(cal_done),
    .motors_off(motors_off), .wd_expired(wd_expired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (send_resp)   n_send <= n_send + 1;
    if (strt_cal)    n_strt <= n_strt + 1;
    if (clr_cmd_rdy) n_clr  <= n_clr + 1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required finish");
    $fatal(1);
  end

  // Presents a command for one accept edge; returns at the falling edge after decode.
  task automatic drive_cmd(input logic [7:0] c, input logic [15:0] d);
    @(negedge clk);
    cmd = c; data = d; cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    $display("cmd %02h data %04h -> resp %02h send_resp %0b", c, d, resp, send_resp);
  endtask

  // From ACK_SEND: moves to ACK_WAIT, then pulses resp_sent to return to IDLE.
  task automatic ack();
    @(negedge clk);
    resp_sent = 1'b1;
    @(negedge clk);
    resp_sent = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (d_ptch !== 16'h0 || d_roll !== 16'h0 || d_yaw !== 16'h0) $display("FAIL reset_setpoints: got %h %h %h want 0", d_ptch, d_roll, d_yaw); else passed++;
    total++; if (thrst !== 9'h0) $display("FAIL reset_thrst: got %h want 0", thrst); else passed++;
    total++; if (motors_off !== 1'b1) $display("FAIL reset_motors_off: got %b want 1", motors_off); else passed++;
    total++; if (resp !== 8'h00) $display("FAIL reset_resp: got %h want 00", resp); else passed++;
    total++; if ({send_resp, clr_cmd_rdy, strt_cal, wd_expired} !== 4'b0000) $display("FAIL reset_pulses: got %b want 0000", {send_resp, clr_cmd_rdy, strt_cal, wd_expired}); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_set_thrst();
    int s0, c0;
    s0 = n_send; c0 = n_clr;
    @(negedge clk);
    cmd = 8'h05; data = 16'h01FF; cmd_rdy = 1'b1;
    #1;
    total++; if (clr_cmd_rdy !== 1'b1) $display("FAIL thrst_clr_comb: got %b want 1", clr_cmd_rdy); else passed++;
    @(negedge clk);
    cmd_rdy = 1'b0;
    $display("cmd 05 data 01ff -> resp %02h send_resp %0b", resp, send_resp);
    total++; if (thrst !== 9'h1FF) $display("FAIL thrst_value: got %h want 1ff", thrst); else passed++;
    total++; if (resp !== 8'hA5) $display("FAIL thrst_resp: got %h want a5", resp); else passed++;
    total++; if (send_resp !== 1'b1) $display("FAIL thrst_send_latency: got %b want 1", send_resp); else passed++;
    ack();
    total++; if (n_send - s0 !== 1) $display("FAIL thrst_send_count: got %0d want 1", n_send - s0); else passed++;
    total++; if (n_clr - c0 !== 1) $display("FAIL thrst_clr_count: got %0d want 1", n_clr - c0); else passed++;
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = n_send;
    drive_cmd(8'h02, 16'hFF38); ack();
    drive_cmd(8'h03, 16'h0064); ack();
    drive_cmd(8'h04, 16'h8000); ack();
    total++; if (d_ptch !== 16'hFF38) $display("FAIL b2b_ptch: got %h want ff38", d_ptch); else passed++;
    total++; if (d_roll !== 16'h0064) $display("FAIL b2b_roll: got %h want 0064", d_roll); else passed++;
    total++; if (d_yaw !== 16'h8000) $display("FAIL b2b_yaw: got %h want 8000", d_yaw); else passed++;
    total++; if (n_send - s0 !== 3) $display("FAIL b2b_send_count: got %0d want 3", n_send - s0); else passed++;
  endtask

  task automatic test_calibrate();
    int s0, t0;
    s0 = n_send; t0 = n_strt;
    drive_cmd(8'h06, 16'h0000);
    total++; if (strt_cal !== 1'b1) $display("FAIL cal_strt_latency: got %b want 1", strt_cal); else passed++;
    for (int i = 0; i < 49; i++) @(negedge clk);
    total++; if (n_send - s0 !== 0) $display("FAIL cal_early_send: got %0d want 0", n_send - s0); else passed++;
    total++; if (motors_off !== 1'b1) $display("FAIL cal_motors_before: got %b want 1", motors_off); else passed++;
    cal_done = 1'b1;
    @(negedge clk);
    cal_done = 1'b0;
    total++; if (motors_off !== 1'b0) $display("FAIL cal_motors_after: got %b want 0", motors_off); else passed++;
    total++; if (send_resp !== 1'b1) $display("FAIL cal_send: got %b want 1", send_resp); else passed++;
    ack();
    total++; if (n_strt - t0 !== 1) $display("FAIL cal_strt_count: got %0d want 1", n_strt - t0); else passed++;
    total++; if (resp !== 8'hA5) $display("FAIL cal_resp: got %h want a5", resp); else passed++;
  endtask

  task automatic test_invalid_and_moff();
    drive_cmd(8'h3C, 16'h1234);
    total++; if (resp !== 8'hEE) $display("FAIL bad_resp: got %h want ee", resp); else passed++;
    total++; if (d_ptch !== 16'hFF38 || d_roll !== 16'h0064 || d_yaw !== 16'h8000 || thrst !== 9'h1FF)
      $display("FAIL bad_no_change: got %h %h %h %h want ff38 0064 8000 1ff", d_ptch, d_roll, d_yaw, thrst); else passed++;
    ack();
    drive_cmd(8'h08, 16'h0000);
    total++; if (motors_off !== 1'b1) $display("FAIL moff_motors: got %b want 1", motors_off); else passed++;
    total++; if (resp !== 8'hA5) $display("FAIL moff_resp: got %h want a5", resp); else passed++;
    total++; if (d_ptch !== 16'hFF38 || thrst !== 9'h1FF) $display("FAIL moff_keep: got %h %h want ff38 1ff", d_ptch, thrst); else passed++;
    ack();
  endtask

  task automatic test_emer_land();
    drive_cmd(8'h07, 16'hFFFF);
    total++; if ({d_ptch, d_roll, d_yaw} !== 48'h0 || thrst !== 9'h0)
      $display("FAIL land_zero: got %h %h %h %h want 0", d_ptch, d_roll, d_yaw, thrst); else passed++;
    ack();
  endtask

  task automatic test_watchdog();
    cal_done = 1'b1;
    drive_cmd(8'h06, 16'h0000);
    total++; if (strt_cal !== 1'b1) $display("FAIL wd_cal_strt: got %b want 1", strt_cal); else passed++;
    @(negedge clk);
    cal_done = 1'b0;
    total++; if ({send_resp, strt_cal, motors_off} !== 3'b100) $display("FAIL cal_done_early_exit: got %b want 100", {send_resp, strt_cal, motors_off}); else passed++;
    ack();
    drive_cmd(8'h05, 16'h0100);
    total++; if (thrst !== 9'h100) $display("FAIL wd_thrst_set: got %h want 100", thrst); else passed++;
    for (int k = 1; k <= 254; k++) begin
      @(negedge clk);
      if (k == 1) resp_sent = 1'b1;
      if (k == 2) resp_sent = 1'b0;
    end
    total++; if (wd_expired !== 1'b0 || thrst !== 9'h100) $display("FAIL wd_early: got %b %h want 0 100", wd_expired, thrst); else passed++;
    @(negedge clk);
    total++; if (wd_expired !== 1'b1) $display("FAIL wd_expire: got %b want 1", wd_expired); else passed++;
    total++; if (thrst !== 9'h0) $display("FAIL wd_thrst_zero: got %h want 0", thrst); else passed++;
    drive_cmd(8'h05, 16'h0080);
    total++; if (wd_expired !== 1'b0) $display("FAIL wd_clear: got %b want 0", wd_expired); else passed++;
    total++; if (thrst !== 9'h080) $display("FAIL wd_thrst_new: got %h want 080", thrst); else passed++;
    @(negedge clk);
    total++; if (thrst !== 9'h080) $display("FAIL wd_thrst_hold: got %h want 080", thrst); else passed++;
    resp_sent = 1'b1;
    @(negedge clk);
    resp_sent = 1'b0;
  endtask

  task automatic test_back_to_back_hold();
    int c0, s0;
    c0 = n_clr; s0 = n_send;
    @(negedge clk);
    cmd = 8'h02; data = 16'h0011; cmd_rdy = 1'b1;
    @(negedge clk);
    cmd = 8'h03; data = 16'h0022;
    $display("cmd 02 data 0011 -> resp %02h send_resp %0b (cmd_rdy held)", resp, send_resp);
    total++; if (d_ptch !== 16'h0011) $display("FAIL hold_first: got %h want 0011", d_ptch); else passed++;
    repeat (4) @(negedge clk);
    total++; if (n_clr - c0 !== 1) $display("FAIL hold_no_redecode: got %0d want 1", n_clr - c0); else passed++;
    total++; if (d_roll !== 16'h0000) $display("FAIL hold_roll_same: got %h want 0000", d_roll); else passed++;
    resp_sent = 1'b1;
    @(negedge clk);
    total++; if (clr_cmd_rdy !== 1'b1) $display("FAIL hold_idle_clr: got %b want 1", clr_cmd_rdy); else passed++;
    resp_sent = 1'b0;
    @(negedge clk);
    cmd_rdy = 1'b0;
    $display("cmd 03 data 0022 -> resp %02h send_resp %0b", resp, send_resp);
    total++; if (d_roll !== 16'h0022) $display("FAIL hold_second: got %h want 0022", d_roll); else passed++;
    ack();
    total++; if (n_send - s0 !== 2) $display("FAIL hold_send_count: got %0d want 2", n_send - s0); else passed++;
  endtask

  task automatic test_reset_in_cal();
    int s0;
    drive_cmd(8'h06, 16'h0000);
    repeat (3) @(negedge clk);
    s0 = n_send;
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (motors_off !== 1'b1) $display("FAIL rcal_motors: got %b want 1", motors_off); else passed++;
    total++; if (resp !== 8'h00 || thrst !== 9'h0 || d_ptch !== 16'h0) $display("FAIL rcal_regs: got %h %h %h want 00 0 0", resp, thrst, d_ptch); else passed++;
    rst_n = 1'b1;
    cal_done = 1'b1;
    repeat (5) @(negedge clk);
    cal_done = 1'b0;
    total++; if (n_send - s0 !== 0) $display("FAIL rcal_no_send: got %0d want 0", n_send - s0); else passed++;
    cmd = 8'h02; data = 16'h0005; cmd_rdy = 1'b1;
    #1;
    total++; if (clr_cmd_rdy !== 1'b1) $display("FAIL rcal_idle: got %b want 1", clr_cmd_rdy); else passed++;
    @(negedge clk);
    cmd_rdy = 1'b0;
    $display("cmd 02 data 0005 -> resp %02h send_resp %0b", resp, send_resp);
    total++; if (d_ptch !== 16'h0005) $display("FAIL rcal_cmd: got %h want 0005", d_ptch); else passed++;
    ack();
  endtask

  initial begin
    test_reset();
    test_set_thrst();
    test_back_to_back();
    test_calibrate();
    test_invalid_and_moff();
    test_emer_land();
    test_watchdog();
    test_back_to_back_hold();
    test_reset_in_cal();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
